mips_debug_controller: RTL and testbench

Command sequencer between the MicroBlaze host and the MIPS core. It accepts 32-bit control frames laid out as {code[31:26], addr_type[25:16], data[15:0]}. It drives MIPS run/step enable, soft reset, instruction-memory loading and debug read-back, and returns exactly one response frame per accepted command. It sits behind the frame pass-through interface and in front of the MIPS pipeline, instruction memory and debug mux.

---
 rtl/mips_debug_defs.sv | 68 ++++++
 rtl/mips_debug_frame_decoder.sv | 30 +++
 rtl/mips_debug_controller.sv | 228 ++++++++++++++++++++++
 tb/tb_mips_debug_controller.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_debug_defs.sv
// Shared definitions for the MIPS debug controller: frame layout, command codes,
// debug-select codes, response encodings and FSM/mode types.
package mips_debug_defs;

  localparam int NB_CODE      = 6;
  localparam int NB_ADDR_TYPE = 10;
  localparam int NB_DATA      = 16;
  localparam int NB_FRAME     = NB_CODE + NB_ADDR_TYPE + NB_DATA;

  typedef logic [NB_CODE-1:0]      code_t;
  typedef logic [NB_ADDR_TYPE-1:0] addr_type_t;
  typedef logic [NB_DATA-1:0]      data_t;
  typedef logic [NB_FRAME-1:0]     word_t;

  typedef struct packed {
    code_t      code;
    addr_type_t addr_type;
    data_t      data;
  } frame_t;

  localparam code_t CMD_START          = 6'b000001;
  localparam code_t CMD_RESET          = 6'b000010;
  localparam code_t CMD_REQ_DATA       = 6'b000011;
  localparam code_t CMD_LOAD_INSTR_LSB = 6'b000100;
  localparam code_t CMD_LOAD_INSTR_MSB = 6'b000101;
  localparam code_t CMD_MODE_GET       = 6'b001000;
  localparam code_t CMD_MODE_SET       = 6'b001001;
  localparam code_t CMD_STEP           = 6'b100000;

  // Debug mux selects carried in addr_type of a REQ_DATA frame
  localparam addr_type_t REQ_PC           = 10'h001;
  localparam addr_type_t REQ_MEM_DATA     = 10'h002;
  localparam addr_type_t REQ_REG          = 10'h004;
  localparam addr_type_t REQ_LATCH_IF_ID  = 10'h008;
  localparam addr_type_t REQ_LATCH_ID_EX  = 10'h010;
  localparam addr_type_t REQ_LATCH_EX_MEM = 10'h020;
  localparam addr_type_t REQ_LATCH_MEM_WB = 10'h040;

  localparam code_t RSP_ERR_CODE  = 6'b111111;
  localparam code_t RSP_HALT_CODE = 6'b111110;
  localparam word_t RSP_HALT      = {RSP_HALT_CODE, 26'd0};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_STEP_PULSE,
    ST_RESET_HOLD,
    ST_READ_WAIT
  } state_e;

  typedef enum logic {
    MODE_CONT = 1'b0,
    MODE_STEP = 1'b1
  } mode_e;

  function automatic word_t ack_frame(input code_t code);
    return {code, 26'd0};
  endfunction

  function automatic word_t err_frame(input code_t code);
    return {RSP_ERR_CODE, 10'd0, 10'd0, code};
  endfunction

  function automatic word_t mode_frame(input mode_e mode);
    return {CMD_MODE_GET, 10'd0, 15'd0, mode};
  endfunction

endpackage

// File: rtl/mips_debug_frame_decoder.sv
// Combinational split of a control frame into its fields, plus a flag telling
// whether the command code is one the controller understands.
module mips_debug_frame_decoder
  import mips_debug_defs::*;
(
  input  logic [NB_FRAME-1:0]     frame,
  output logic [NB_CODE-1:0]      code,
  output logic [NB_ADDR_TYPE-1:0] addr_type,
  output logic [NB_DATA-1:0]      data,
  output logic                    code_valid
);

  frame_t fields;

  assign fields    = frame_t'(frame);
  assign code      = fields.code;
  assign addr_type = fields.addr_type;
  assign data      = fields.data;

  always_comb begin
    case (fields.code)
      CMD_START, CMD_RESET, CMD_REQ_DATA, CMD_LOAD_INSTR_LSB,
      CMD_LOAD_INSTR_MSB, CMD_MODE_GET, CMD_MODE_SET, CMD_STEP:
        code_valid = 1'b1;
      default:
        code_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_debug_controller.sv
// Command sequencer between the MicroBlaze host and the MIPS core: runs/steps the
// pipeline, pulses soft reset, loads instruction memory and serves debug reads.
module mips_debug_controller
  import mips_debug_defs::*;
#(
  parameter int NB_CONTROL_FRAME = 32,
  parameter int NB_INSTR_ADDR    = 10,
  parameter int RESET_CYCLES     = 4,
  parameter int DBG_TIMEOUT      = 16
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic [NB_CONTROL_FRAME-1:0] i_frame_from_blaze,
  input  logic                        i_frame_valid,
  output logic [NB_CONTROL_FRAME-1:0] o_frame_to_blaze,
  output logic                        o_frame_valid,
  output logic                        o_busy,
  output logic                        o_mips_enable,
  output logic                        o_mips_reset,
  output logic                        o_imem_we,
  output logic [NB_INSTR_ADDR-1:0]    o_imem_addr,
  output logic [NB_CONTROL_FRAME-1:0] o_imem_data,
  output logic                        o_dbg_req,
  output logic [NB_ADDR_TYPE-1:0]     o_dbg_sel,
  output logic [NB_DATA-1:0]          o_dbg_index,
  input  logic [NB_CONTROL_FRAME-1:0] i_dbg_data,
  input  logic                        i_dbg_valid,
  input  logic                        i_mips_halt
);

  localparam int CNT_MAX = (DBG_TIMEOUT > RESET_CYCLES) ? DBG_TIMEOUT : RESET_CYCLES;
  localparam int NB_CNT  = $clog2(CNT_MAX + 1);
  localparam logic [NB_CNT-1:0] RESET_LAST   = NB_CNT'(RESET_CYCLES - 1);
  localparam logic [NB_CNT-1:0] TIMEOUT_LAST = NB_CNT'(DBG_TIMEOUT - 1);

  code_t      dec_code;
  addr_type_t dec_addr_type;
  data_t      dec_data;
  logic       dec_code_valid;

  mips_debug_frame_decoder u_decoder (
    .frame      (i_frame_from_blaze),
    .code       (dec_code),
    .addr_type  (dec_addr_type),
    .data       (dec_data),
    .code_valid (dec_code_valid)
  );

  state_e                      state, state_next;
  mode_e                       mode, mode_next;
  logic                        armed, armed_next;
  data_t                       lsb, lsb_next;
  logic [NB_CNT-1:0]           cnt, cnt_next;
  logic                        rsp_valid, rsp_valid_next;
  logic [NB_CONTROL_FRAME-1:0] rsp_frame, rsp_frame_next;
  logic                        imem_we, imem_we_next;
  logic [NB_INSTR_ADDR-1:0]    imem_addr, imem_addr_next;
  logic [NB_CONTROL_FRAME-1:0] imem_data, imem_data_next;
  addr_type_t                  dbg_sel, dbg_sel_next;
  data_t                       dbg_index, dbg_index_next;

  // State register and datapath registers
  always_ff @(posedge i_clock) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!i_reset) begin
      state     <= ST_IDLE;
      mode      <= MODE_CONT;
      armed     <= 1'b0;
      lsb       <= '0;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_frame <= '0;
      imem_we   <= 1'b0;
      imem_addr <= '0;
      imem_data <= '0;
      dbg_sel   <= '0;
      dbg_index <= '0;
    end else begin
      state     <= state_next;
      mode      <= mode_next;
      armed     <= armed_next;
      lsb       <= lsb_next;
      cnt       <= cnt_next;
      rsp_valid <= rsp_valid_next;
      rsp_frame <= rsp_frame_next;
      imem_we   <= imem_we_next;
      imem_addr <= imem_addr_next;
      imem_data <= imem_data_next;
      dbg_sel   <= dbg_sel_next;
      dbg_index <= dbg_index_next;
    end
  end

  // Next-state and next-datapath logic
  always_comb begin
    // NOTE: defaults first so no path through the case infers a latch.
    state_next     = state;
    mode_next      = mode;
    armed_next     = armed;
    lsb_next       = lsb;
    cnt_next       = '0;
    rsp_valid_next = 1'b0;
    rsp_frame_next = '0;
    imem_we_next   = 1'b0;
    imem_addr_next = imem_addr;
    imem_data_next = imem_data;
    dbg_sel_next   = dbg_sel;
    dbg_index_next = dbg_index;

    case (state)
      ST_IDLE: begin
        if (i_frame_valid) begin
          rsp_valid_next = 1'b1;
          rsp_frame_next = ack_frame(dec_code);
          if (!dec_code_valid) begin
            rsp_frame_next = err_frame(dec_code);
          end else begin
            case (dec_code)
              CMD_START: begin
                if (mode == MODE_CONT) state_next = ST_RUN;
                else                   armed_next = 1'b1;
              end
              CMD_STEP: begin
                // The step ACK follows the enable pulse, so none is sent now
                if (armed) begin
                  state_next     = ST_STEP_PULSE;
                  rsp_valid_next = 1'b0;
                end else begin
                  rsp_frame_next = err_frame(dec_code);
                end
              end
              CMD_MODE_SET: begin
                mode_next  = mode_e'(dec_data[0]);
                armed_next = 1'b0;
              end
              CMD_MODE_GET: rsp_frame_next = mode_frame(mode);
              CMD_LOAD_INSTR_LSB: lsb_next = dec_data;
              CMD_LOAD_INSTR_MSB: begin
                imem_we_next   = 1'b1;
                imem_addr_next = dec_addr_type[NB_INSTR_ADDR-1:0];
                imem_data_next = {dec_data, lsb};
              end
              CMD_REQ_DATA: begin
                state_next     = ST_READ_WAIT;
                dbg_sel_next   = dec_addr_type;
                dbg_index_next = dec_data;
                rsp_valid_next = 1'b0;
              end
              CMD_RESET: begin
                state_next     = ST_RESET_HOLD;
                armed_next     = 1'b0;
                rsp_valid_next = 1'b0;
              end
              default: rsp_frame_next = err_frame(dec_code);
            endcase
          end
        end
      end

      ST_RUN: begin
        // Halt has priority over a frame arriving in the same cycle
        if (i_mips_halt) begin
          state_next     = ST_IDLE;
          armed_next     = 1'b0;
          rsp_valid_next = 1'b1;
          rsp_frame_next = RSP_HALT;
        end else if (i_frame_valid) begin
          if (dec_code == CMD_RESET) begin
            state_next = ST_RESET_HOLD;
            armed_next = 1'b0;
          end else begin
            rsp_valid_next = 1'b1;
            rsp_frame_next = err_frame(dec_code);
          end
        end
      end

      ST_STEP_PULSE: begin
        state_next     = ST_IDLE;
        rsp_valid_next = 1'b1;
        rsp_frame_next = ack_frame(CMD_STEP);
      end

      ST_RESET_HOLD: begin
        if (cnt == RESET_LAST) begin
          state_next     = ST_IDLE;
          rsp_valid_next = 1'b1;
          rsp_frame_next = ack_frame(CMD_RESET);
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end

      ST_READ_WAIT: begin
        if (i_dbg_valid) begin
          state_next     = ST_IDLE;
          rsp_valid_next = 1'b1;
          rsp_frame_next = i_dbg_data;
        end else if (cnt == TIMEOUT_LAST) begin
          state_next     = ST_IDLE;
          rsp_valid_next = 1'b1;
          rsp_frame_next = err_frame(CMD_REQ_DATA);
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    o_busy        = !(state == ST_IDLE || state == ST_RUN);
    o_mips_enable = (state == ST_RUN) || (state == ST_STEP_PULSE);
    o_mips_reset  = (state == ST_RESET_HOLD);
    o_dbg_req     = (state == ST_READ_WAIT);
  end

  assign o_frame_to_blaze = rsp_frame;
  assign o_frame_valid    = rsp_valid;
  assign o_imem_we        = imem_we;
  assign o_imem_addr      = imem_addr;
  assign o_imem_data      = imem_data;
  assign o_dbg_sel        = dbg_sel;
  assign o_dbg_index      = dbg_index;

endmodule

// File: tb/tb_mips_debug_controller.sv
// Directed bench for mips_debug_controller: hand-computed response frames and
// pulse counts collected by a negedge monitor.
module tb_mips_debug_controller;
  import mips_debug_defs::*;

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic [31:0] i_frame_from_blaze;
  logic        i_frame_valid;
  logic [31:0] o_frame_to_blaze;
  logic        o_frame_valid;
  logic        o_busy;
  logic        o_mips_enable;
  logic        o_mips_reset;
  logic        o_imem_we;
  logic [9:0]  o_imem_addr;
  logic [31:0] o_imem_data;
  logic        o_dbg_req;
  logic [9:0]  o_dbg_sel;
  logic [15:0] o_dbg_index;
  logic [31:0] i_dbg_data;
  logic        i_dbg_valid;
  logic        i_mips_halt;

  mips_debug_controller dut (
    .i_clock            (i_clock),
    .i_reset            (i_reset),
    .i_frame_from_blaze (i_frame_from_blaze),
    .i_frame_valid      (i_frame_valid),
    .o_frame_to_blaze   (o_frame_to_blaze),
    .o_frame_valid      (o_frame_valid),
    .o_busy             (o_busy),
    .o_mips_enable      (o_mips_enable),
    .o_mips_reset       (o_mips_reset),
    .o_imem_we          (o_imem_we),
    .o_imem_addr        (o_imem_addr),
    .o_imem_data        (o_imem_data),
    .o_dbg_req          (o_dbg_req),
    .o_dbg_sel          (o_dbg_sel),
    .o_dbg_index        (o_dbg_index),
    .i_dbg_data         (i_dbg_data),
    .i_dbg_valid        (i_dbg_valid),
    .i_mips_halt        (i_mips_halt)
  );

  always #5 i_clock = ~i_clock;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] rsp_q[$];
  int          en_cycles = 0, en_rises = 0, we_cnt = 0, rst_cnt = 0, rst_en_cnt = 0, req_cnt = 0;
  logic        en_prev = 1'b0;

  always @(negedge i_clock) begin
    if (o_frame_valid === 1'b1) rsp_q.push_back(o_frame_to_blaze);
    if (o_mips_enable === 1'b1) begin
      en_cycles++;
      if (!en_prev) en_rises++;
    end
    en_prev = (o_mips_enable === 1'b1);
    if (o_imem_we === 1'b1) we_cnt++;
    if (o_mips_reset === 1'b1) rst_cnt++;
    if (o_mips_reset === 1'b1 && o_mips_enable === 1'b1) rst_en_cnt++;
    if (o_dbg_req === 1'b1) req_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge i_clock);
      #1;
    end
  endtask

  task automatic send(input logic [5:0] code, input logic [9:0] at, input logic [15:0] d);
    i_frame_from_blaze = {code, at, d};
    i_frame_valid      = 1'b1;
    tick();
    i_frame_valid      = 1'b0;
    i_frame_from_blaze = '0;
  endtask

  task automatic expect_rsp(input string tag, input logic [31:0] exp);
    logic [31:0] got;
    for (int i = 0; i < 40 && rsp_q.size() == 0; i++) tick();
    check({tag, "_seen"}, 32'(rsp_q.size() != 0), 32'd1);
    if (rsp_q.size() != 0) begin
      got = rsp_q.pop_front();
      check(tag, got, exp);
    end
  endtask

  task automatic expect_quiet(input string tag, input int n);
    tick(n);
    check(tag, 32'(rsp_q.size()), 32'd0);
    rsp_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, r0, w0, q0;
    i_reset = 1'b0; i_frame_from_blaze = '0; i_frame_valid = 1'b0;
    i_dbg_data = '0; i_dbg_valid = 1'b0; i_mips_halt = 1'b0;
    tick(3);
    check("rst_valid",  32'(o_frame_valid), 32'd0);
    check("rst_busy",   32'(o_busy),        32'd0);
    check("rst_enable", 32'(o_mips_enable), 32'd0);
    check("rst_mreset", 32'(o_mips_reset),  32'd0);
    check("rst_we",     32'(o_imem_we),     32'd0);
    check("rst_req",    32'(o_dbg_req),     32'd0);
    i_reset = 1'b1;
    tick();

    // Instruction load: LSB then MSB
    w0 = we_cnt;
    send(CMD_LOAD_INSTR_LSB, 10'd0, 16'h5678);
    expect_rsp("ack_lsb", 32'h1000_0000);
    send(CMD_LOAD_INSTR_MSB, 10'h003, 16'h1234);
    check("imem_we",   32'(o_imem_we),   32'd1);
    check("imem_addr", 32'(o_imem_addr), 32'h3);
    check("imem_data", o_imem_data,      32'h1234_5678);
    expect_rsp("ack_msb", 32'h1400_0000);
    tick(2);
    check("imem_we_pulses", 32'(we_cnt - w0), 32'd1);

    // Step mode
    send(CMD_MODE_SET, 10'd0, 16'h0001);
    expect_rsp("ack_mode_step", 32'h2400_0000);
    send(CMD_STEP, 10'd0, 16'd0);
    expect_rsp("err_step_unarmed", 32'hFC00_0020);
    e0 = en_cycles; r0 = en_rises;
    send(CMD_START, 10'd0, 16'd0);
    check("start_step_no_en", 32'(o_mips_enable), 32'd0);
    expect_rsp("ack_start_step", 32'h0400_0000);
    for (int s = 0; s < 3; s++) begin
      send(CMD_STEP, 10'd0, 16'd0);
      expect_rsp("ack_step", 32'h8000_0000);
      tick();
    end
    check("step_en_cycles", 32'(en_cycles - e0), 32'd3);
    check("step_en_pulses", 32'(en_rises - r0),  32'd3);
    send(CMD_MODE_GET, 10'd0, 16'd0);
    expect_rsp("mode_get_step", 32'h2000_0001);

    // Continuous run, ERR while running, then halt
    send(CMD_MODE_SET, 10'd0, 16'h0000);
    expect_rsp("ack_mode_cont", 32'h2400_0000);
    e0 = en_cycles;
    send(CMD_START, 10'd0, 16'd0);
    check("run_enable", 32'(o_mips_enable), 32'd1);
    expect_rsp("ack_start_run", 32'h0400_0000);
    send(CMD_STEP, 10'd0, 16'd0);
    expect_rsp("err_step_running", 32'hFC00_0020);
    tick(10);
    check("run_enable_pre_halt", 32'(o_mips_enable), 32'd1);
    i_mips_halt = 1'b1;
    tick();
    i_mips_halt = 1'b0;
    check("halt_enable_drop", 32'(o_mips_enable), 32'd0);
    expect_rsp("halt_frame", 32'hF800_0000);
    check("run_len_ge10", 32'((en_cycles - e0) >= 10), 32'd1);

    // Halt and a RESET frame in the same cycle: halt wins
    send(CMD_START, 10'd0, 16'd0);
    expect_rsp("ack_start_run2", 32'h0400_0000);
    i_frame_from_blaze = {CMD_RESET, 26'd0};
    i_frame_valid = 1'b1; i_mips_halt = 1'b1;
    tick();
    i_frame_valid = 1'b0; i_mips_halt = 1'b0; i_frame_from_blaze = '0;
    check("halt_wins_no_reset", 32'(o_mips_reset), 32'd0);
    expect_rsp("halt_wins_frame", 32'hF800_0000);
    expect_quiet("halt_wins_quiet", 8);

    // Debug read served after 3 cycles; a frame during the wait is dropped
    send(CMD_REQ_DATA, REQ_REG, 16'd5);
    check("dbg_req",   32'(o_dbg_req),   32'd1);
    check("dbg_busy",  32'(o_busy),      32'd1);
    check("dbg_sel",   32'(o_dbg_sel),   32'h004);
    check("dbg_index", 32'(o_dbg_index), 32'd5);
    send(CMD_MODE_GET, 10'd0, 16'd0);
    tick();
    i_dbg_data = 32'hDEAD_BEEF; i_dbg_valid = 1'b1;
    tick();
    i_dbg_valid = 1'b0; i_dbg_data = '0;
    check("dbg_req_drop", 32'(o_dbg_req), 32'd0);
    expect_rsp("dbg_data", 32'hDEAD_BEEF);
    expect_quiet("busy_drop_quiet", 6);

    // Debug read timeout
    q0 = req_cnt;
    send(CMD_REQ_DATA, REQ_REG, 16'd5);
    expect_rsp("dbg_timeout", 32'hFC00_0003);
    check("dbg_req_cycles", 32'(req_cnt - q0), 32'd16);

    // Undefined code
    send(6'b010101, 10'd0, 16'd0);
    expect_rsp("err_undef", 32'hFC00_0015);

    // RESET during RUN
    send(CMD_START, 10'd0, 16'd0);
    expect_rsp("ack_start_run3", 32'h0400_0000);
    r0 = rst_cnt; e0 = rst_en_cnt;
    send(CMD_RESET, 10'd0, 16'd0);
    check("reset_hold_mreset", 32'(o_mips_reset),  32'd1);
    check("reset_hold_enable", 32'(o_mips_enable), 32'd0);
    expect_rsp("ack_reset_run", 32'h0800_0000);
    check("reset_cycles", 32'(rst_cnt - r0),    32'd4);
    check("reset_no_en",  32'(rst_en_cnt - e0), 32'd0);
    send(CMD_MODE_GET, 10'd0, 16'd0);
    expect_rsp("mode_get_cont", 32'h2000_0000);

    // RESET from IDLE in step mode keeps mode, clears armed
    send(CMD_MODE_SET, 10'd0, 16'h0001);
    expect_rsp("ack_mode_step2", 32'h2400_0000);
    send(CMD_START, 10'd0, 16'd0);
    expect_rsp("ack_start_arm", 32'h0400_0000);
    send(CMD_RESET, 10'd0, 16'd0);
    expect_rsp("ack_reset_idle", 32'h0800_0000);
    send(CMD_MODE_GET, 10'd0, 16'd0);
    expect_rsp("mode_preserved", 32'h2000_0001);
    send(CMD_STEP, 10'd0, 16'd0);
    expect_rsp("err_step_disarmed", 32'hFC00_0020);

    // Block reset in READ_WAIT aborts with no response
    send(CMD_REQ_DATA, REQ_MEM_DATA, 16'd9);
    tick();
    i_reset = 1'b0;
    tick();
    check("abort_req",   32'(o_dbg_req),     32'd0);
    check("abort_busy",  32'(o_busy),        32'd0);
    check("abort_valid", 32'(o_frame_valid), 32'd0);
    check("abort_sel",   32'(o_dbg_sel),     32'd0);
    i_reset = 1'b1;
    expect_quiet("abort_quiet", 24);
    send(CMD_LOAD_INSTR_MSB, 10'h007, 16'hAAAA);
    check("lsb_cleared_data", o_imem_data,      32'hAAAA_0000);
    check("lsb_cleared_addr", 32'(o_imem_addr), 32'h7);
    expect_rsp("ack_msb2", 32'h1400_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
